// File: rtl/alu_issue_ctrl.sv
// Registered ALU-select issue stage: decodes {alu_op, funct}, sequences MUL/DIV latency, handshakes both sides.
// Optional build macro ALU_ISSUE_PERF_EN adds perf_issued/perf_stall counters.
module alu_issue_ctrl #(
    parameter int OP_W    = 5,
    parameter int FUNCT_W = 6,
    parameter int SEL_W   = 6,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   alu_select,
    output logic               busy,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_stall,
`endif
    output logic               illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, VALID} state_e;
    typedef enum logic [1:0] {CLS_SINGLE, CLS_MUL, CLS_DIV} cls_e;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    // Returns {illegal, select[4:0]}
    function automatic logic [5:0] decode(input logic [OP_W-1:0] op, input logic [FUNCT_W-1:0] fn);
        logic [4:0] s;
        logic       ill;
        s   = 5'h00;
        ill = 1'b0;
        if (op == '0) begin
            case (fn)
                6'h26: s = 5'h00;
                6'h25: s = 5'h01;
                6'h27: s = 5'h02;
                6'h24: s = 5'h03;
                6'h20: s = 5'h04;
                6'h22: s = 5'h05;
                6'h21: s = 5'h06;
                6'h23: s = 5'h07;
                6'h18: s = 5'h08;
                6'h1A: s = 5'h09;
                6'h00: s = 5'h0A;
                6'h04: s = 5'h0B;
                6'h02: s = 5'h0C;
                6'h06: s = 5'h0D;
                6'h03: s = 5'h0E;
                6'h2A: s = 5'h0F;
                6'h0C: s = 5'h10;
                6'h08: s = 5'h11;
                default: ill = 1'b1;
            endcase
        end else begin
            case (op) inside
                5'h01:          s = 5'h04;
                5'h02:          s = 5'h06;
                5'h03:          s = 5'h03;
                5'h04:          s = 5'h00;
                5'h05:          s = 5'h01;
                [5'h06:5'h0A]:  s = 5'(op) + 5'h10;
                [5'h0B:5'h0E]:  s = 5'h04;
                [5'h0F:5'h1B]:  s = 5'(op) + 5'h03;
                [5'h1C:5'h1E]:  s = 5'h16;
                default:        ill = 1'b1;
            endcase
        end
        return {ill, s};
    endfunction

    function automatic cls_e op_class(input logic [OP_W-1:0] op, input logic [FUNCT_W-1:0] fn);
        if ((op == '0 && fn == 6'h18) || op == 5'h15)
            return CLS_MUL;
        if ((op == '0 && fn == 6'h1A) || op == 5'h16 || op == 5'h17)
            return CLS_DIV;
        return CLS_SINGLE;
    endfunction

    state_e           state_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             illegal_q;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] cnt_q;

    logic [5:0]       dec_d;
    logic [SEL_W-1:0] sel_d;
    logic             illegal_d;
    cls_e             cls_d;
    logic             accept;

    always_comb begin
        dec_d     = decode(alu_op, funct);
        sel_d     = SEL_W'(dec_d[4:0]);
        illegal_d = dec_d[5];
        cls_d     = op_class(alu_op, funct);
    end

    assign in_ready   = !rst && !flush && (state_q == IDLE || (state_q == VALID && out_ready));
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign illegal    = illegal_q;
    assign alu_select = sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
            sel_q       <= '0;
            cnt_q       <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else if (accept) begin
            sel_q     <= sel_d;
            illegal_q <= illegal_d;
            case (cls_d)
                CLS_MUL: begin
                    state_q     <= EXEC;
                    cnt_q       <= MUL_CNT;
                    busy_q      <= 1'b1;
                    out_valid_q <= 1'b0;
                end
                CLS_DIV: begin
                    state_q     <= EXEC;
                    cnt_q       <= DIV_CNT;
                    busy_q      <= 1'b1;
                    out_valid_q <= 1'b0;
                end
                default: begin
                    state_q     <= VALID;
                    cnt_q       <= '0;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                end
            endcase
        end else begin
            case (state_q)
                EXEC: begin
                    // Counter was loaded with LAT-1, so VALID lands LAT edges after accept
                    if (cnt_q == '0) begin
                        state_q     <= VALID;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_stall_q;

    // Counters survive flush; only rst clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (accept)
                perf_issued_q <= perf_issued_q + 32'd1;
            if (in_valid && !in_ready)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`else
    // Build without performance counters.
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized + directed bench for alu_issue_ctrl against a table-driven issue model.
// Checks perf counters too when ALU_ISSUE_PERF_EN is defined.
module tb_alu_issue_ctrl;
    localparam int OP_W    = 5;
    localparam int FUNCT_W = 6;
    localparam int SEL_W   = 6;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;
    localparam int CNT_W   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, flush, in_valid, in_ready, out_valid, out_ready, busy, illegal;
    logic [OP_W-1:0]    alu_op;
    logic [FUNCT_W-1:0] funct;
    logic [SEL_W-1:0]   alu_select;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0]        perf_issued, perf_stall;
`endif

    alu_issue_ctrl #(
        .OP_W(OP_W), .FUNCT_W(FUNCT_W), .SEL_W(SEL_W),
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_select(alu_select), .busy(busy),
`ifdef ALU_ISSUE_PERF_EN
        .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
        .illegal(illegal)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // funct codes for alu_op=00, listed in order of the select value they produce
    int ftab[18] = '{'h26, 'h25, 'h27, 'h24, 'h20, 'h22, 'h21, 'h23, 'h18,
                     'h1A, 'h00, 'h04, 'h02, 'h06, 'h03, 'h2A, 'h0C, 'h08};
    // select value for each nonzero alu_op (entry 0 unused, 1F is illegal)
    int optab[32] = '{'h00, 'h04, 'h06, 'h03, 'h00, 'h01, 'h16, 'h17,
                      'h18, 'h19, 'h1A, 'h04, 'h04, 'h04, 'h04, 'h12,
                      'h13, 'h14, 'h15, 'h16, 'h17, 'h18, 'h19, 'h1A,
                      'h1B, 'h1C, 'h1D, 'h1E, 'h16, 'h16, 'h16, 'h00};

    // Model: an op is held until edges-remaining reaches 0, then presented until taken
    bit          m_has;
    int          m_rem;
    int          m_sel;
    bit          m_ill;
    int unsigned m_iss, m_stl;

    function automatic int ref_sel(input int op, input int fn, output bit ill);
        int s;
        s   = 0;
        ill = 1'b0;
        if (op == 0) begin
            ill = 1'b1;
            for (int i = 0; i < 18; i++)
                if (ftab[i] == fn) begin
                    s   = i;
                    ill = 1'b0;
                end
        end else begin
            s   = optab[op];
            ill = (op == 'h1F);
        end
        return s;
    endfunction

    function automatic int ref_lat(input int op, input int fn);
        if ((op == 0 && fn == 'h18) || op == 'h15) return MUL_LAT;
        if ((op == 0 && fn == 'h1A) || op == 'h16 || op == 'h17) return DIV_LAT;
        return 0;
    endfunction

    function automatic bit exp_rdy();
        return !rst && !flush && (!m_has || (m_rem == 0 && out_ready));
    endfunction

    task automatic cyc(input bit r, input bit f, input bit v, input int op, input int fn, input bit ordy);
        bit rdy;
        @(negedge clk);
        rst       = r;
        flush     = f;
        in_valid  = v;
        alu_op    = op[4:0];
        funct     = fn[5:0];
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, exp_rdy());
        chk("out_valid", out_valid, m_has && m_rem == 0);
        chk("busy", busy, m_has && m_rem > 0);
        if (m_has && m_rem == 0) begin
            chk("alu_select", alu_select, m_sel);
            chk("illegal", illegal, m_ill);
        end
        chk("ill_busy", illegal & busy, 0);
        @(posedge clk);
        rdy = exp_rdy();
        if (r) begin
            m_has = 0; m_rem = 0; m_sel = 0; m_ill = 0; m_iss = 0; m_stl = 0;
        end else begin
            if (v && rdy)  m_iss++;
            if (v && !rdy) m_stl++;
            if (f) begin
                m_has = 0;
                m_rem = 0;
            end else if (v && rdy) begin
                m_sel = ref_sel(op, fn, m_ill);
                m_rem = ref_lat(op, fn);
                m_has = 1;
            end else if (m_has && m_rem > 0) begin
                m_rem--;
            end else if (m_has && ordy) begin
                m_has = 0;
            end
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_op = '0; funct = '0; out_ready = 1'b1;
        m_has = 0; m_rem = 0; m_sel = 0; m_ill = 0; m_iss = 0; m_stl = 0;
        repeat (2) @(posedge clk);

        cyc(1, 0, 0, 0, 0, 1);
        #1;
        chk("rst_sel", alu_select, 0);
        chk("rst_ill", illegal, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_busy", busy, 0);

        cyc(0, 0, 1, 0, 'h20, 1);
        #1; chk("add_sel", alu_select, 'h04); chk("add_vld", out_valid, 1); chk("add_ill", illegal, 0);
        cyc(0, 0, 1, 'h01, 0, 1); #1; chk("stream0", alu_select, 'h04); chk("stream0_vld", out_valid, 1);
        cyc(0, 0, 1, 'h0F, 0, 1); #1; chk("stream1", alu_select, 'h12); chk("stream1_vld", out_valid, 1);
        cyc(0, 0, 1, 'h10, 0, 1); #1; chk("stream2", alu_select, 'h13); chk("stream2_vld", out_valid, 1);
        cyc(0, 0, 0, 0, 0, 1);

        cyc(0, 0, 1, 0, 'h1A, 1);
        n = 0; #1;
        while (!out_valid && n < 40) begin
            cyc(0, 0, 1, 'h01, 0, 0);
            n++; #1;
        end
        chk("div_lat", n, DIV_LAT);
        chk("div_sel", alu_select, 'h09);
        cyc(0, 0, 0, 0, 0, 1);

        cyc(0, 0, 1, 'h15, 0, 1);
        n = 0; #1;
        while (!out_valid && n < 40) begin
            cyc(0, 0, 1, 'h02, 0, 0);
            n++; #1;
        end
        chk("mul_lat", n, MUL_LAT);
        chk("mul_sel", alu_select, 'h18);
        cyc(0, 0, 0, 0, 0, 1);

        cyc(0, 0, 1, 0, 'h22, 0);
        repeat (3) begin
            cyc(0, 0, 0, 0, 0, 0);
            #1; chk("hold_sel", alu_select, 'h05); chk("hold_vld", out_valid, 1);
        end
        cyc(0, 0, 1, 'h03, 0, 1);
        #1; chk("nobubble_sel", alu_select, 'h03); chk("nobubble_vld", out_valid, 1);
        cyc(0, 0, 0, 0, 0, 1);

        cyc(0, 0, 1, 0, 'h1A, 1);
        repeat (4) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);
        #1; chk("flush_busy", busy, 0); chk("flush_vld", out_valid, 0);
        cyc(0, 0, 0, 0, 0, 1);

        cyc(0, 0, 1, 'h16, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        #1;
        chk("rstx_busy", busy, 0); chk("rstx_vld", out_valid, 0);
        chk("rstx_sel", alu_select, 0); chk("rstx_ill", illegal, 0);
        cyc(0, 0, 0, 0, 0, 1);

        cyc(0, 0, 1, 'h1F, 0, 1); #1; chk("ill1f_sel", alu_select, 0); chk("ill1f", illegal, 1);
        cyc(0, 0, 1, 0, 'h3F, 1); #1; chk("ill3f_sel", alu_select, 0); chk("ill3f", illegal, 1);
        cyc(0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            int op, fn;
            bit r, f, v, o;
            r = ($urandom_range(0, 99) == 0);
            f = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 2) != 0);
            o = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: begin op = 0; fn = ftab[$urandom_range(0, 17)]; end
                1: begin op = 0; fn = $urandom_range(0, 63); end
                2: begin op = $urandom_range('h15, 'h17); fn = $urandom_range(0, 63); end
                default: begin op = $urandom_range(0, 31); fn = $urandom_range(0, 63); end
            endcase
            cyc(r, f, v, op, fn, o);
        end

        cyc(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 'h01, 0, 1);
        repeat (4) cyc(0, 0, 1, 'h02, 0, 0);
`ifdef ALU_ISSUE_PERF_EN
        #1;
        chk("perf_issued", perf_issued, 10);
        chk("perf_stall", perf_stall, 4);
        chk("perf_iss_model", perf_issued, m_iss);
        chk("perf_stl_model", perf_stall, m_stl);
`endif
        cyc(0, 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
